// File: rtl/gsens_spi_reader_if.sv
// Pin/data bundle between the ADXL345 SPI reader and its surroundings
// (sensor pins on one side, the 10-bit X sample toward the tilt parser).
interface gsens_spi_reader_if;
  logic       oG_SCLK;
  logic       oG_CS_N;
  logic       oG_SDI;
  logic       iG_SDO;
  logic       iG_INT2;
  logic [9:0] oDIG;
  logic       oDIG_VALID;
  logic       oINIT_DONE;

  modport master (
    output oG_SCLK, oG_CS_N, oG_SDI, oDIG, oDIG_VALID, oINIT_DONE,
    input  iG_SDO, iG_INT2
  );

  modport slave (
    input  oG_SCLK, oG_CS_N, oG_SDI, oDIG, oDIG_VALID, oINIT_DONE,
    output iG_SDO, iG_INT2
  );
endinterface

// File: rtl/gsens_spi_reader.sv
// SPI mode-3 master: configures the ADXL345 and reads X on each INT2 data-ready.
// Optional macro GSENS_POLL_EN adds a watchdog poll that reads even without INT2.
module gsens_spi_reader #(
  parameter int CLK_DIV     = 25,
  parameter int CS_GAP      = 4,
  parameter int POLL_CYCLES = 500000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  gsens_spi_reader_if.master bus
);

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_INIT_XFER = 3'd1;
  localparam logic [2:0] ST_INIT_GAP  = 3'd2;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd3;
  localparam logic [2:0] ST_READ      = 3'd4;
  localparam logic [2:0] ST_UPDATE    = 3'd5;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_LEAD = 3'd1;
  localparam logic [2:0] PH_LOW  = 3'd2;
  localparam logic [2:0] PH_HIGH = 3'd3;
  localparam logic [2:0] PH_TAIL = 3'd4;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(CS_GAP);

  logic [2:0]       state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [4:0]       last_bit_q, last_bit_d;
  logic [23:0]      tx_q, tx_d;
  logic [15:0]      rx_q, rx_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             sdi_q, sdi_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       idx_q, idx_d;
  logic [9:0]       dig_q, dig_d;
  logic             dig_valid_q, dig_valid_d;
  logic             init_done_q, init_done_d;
  logic             int_meta_q, int_meta_d, int_sync_q, int_sync_d;
  logic             sdo_meta_q, sdo_meta_d, sdo_sync_q, sdo_sync_d;

  logic        start;
  logic [23:0] start_frame;
  logic [4:0]  start_last;
  logic        xfer_done;
  logic        read_start;
  logic        poll_hit;

  // Configuration writes issued after reset, as {addr[5:0], data[7:0]}.
  function automatic logic [13:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = {6'h2C, 8'h0A};
      3'd1:    init_word = {6'h31, 8'h00};
      3'd2:    init_word = {6'h2E, 8'h80};
      3'd3:    init_word = {6'h2F, 8'h80};
      default: init_word = {6'h2D, 8'h08};
    endcase
  endfunction

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    div_d       = div_q;
    bit_d       = bit_q;
    last_bit_d  = last_bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    sdi_d       = sdi_q;
    gap_d       = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
    idx_d       = idx_q;
    dig_d       = dig_q;
    dig_valid_d = 1'b0;
    init_done_d = init_done_q;
    int_meta_d  = bus.iG_INT2;
    int_sync_d  = int_meta_q;
    sdo_meta_d  = bus.iG_SDO;
    sdo_sync_d  = sdo_meta_q;
    start       = 1'b0;
    start_frame = '0;
    start_last  = 5'd0;
    xfer_done   = 1'b0;
    read_start  = 1'b0;

    // Bit engine: SDI moves on SCLK fall, SDO is taken on SCLK rise.
    case (phase_q)
      PH_LEAD: begin
        if (div_q == '0) begin
          sclk_d  = 1'b0;
          phase_d = PH_LOW;
          div_d   = DIV_RELOAD;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      PH_LOW: begin
        if (div_q == '0) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[14:0], sdo_sync_q};
          phase_d = PH_HIGH;
          div_d   = DIV_RELOAD;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      PH_HIGH: begin
        if (div_q == '0) begin
          div_d = DIV_RELOAD;
          if (bit_q == last_bit_q) begin
            phase_d = PH_TAIL;
          end else begin
            bit_d   = bit_q + 5'd1;
            sclk_d  = 1'b0;
            sdi_d   = tx_q[23];
            tx_d    = {tx_q[22:0], 1'b0};
            phase_d = PH_LOW;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      PH_TAIL: begin
        if (div_q == '0) begin
          cs_n_d    = 1'b1;
          phase_d   = PH_IDLE;
          xfer_done = 1'b1;
          gap_d     = GAP_W'(1);
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      default: ;
    endcase

    case (state_q)
      ST_INIT: begin
        if (gap_q == GAP_MAX) begin
          start       = 1'b1;
          start_frame = {2'b00, init_word(idx_q), 8'h00};
          start_last  = 5'd15;
          state_d     = ST_INIT_XFER;
        end
      end
      ST_INIT_XFER: if (xfer_done) state_d = ST_INIT_GAP;
      ST_INIT_GAP: begin
        if (gap_q == GAP_MAX) begin
          if (idx_q == 3'd4) begin
            init_done_d = 1'b1;
            state_d     = ST_WAIT_TRIG;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_INIT;
          end
        end
      end
      ST_WAIT_TRIG: begin
        // Level-sensitive: INT2 still high after the gap yields another read.
        if ((gap_q == GAP_MAX) && (int_sync_q || poll_hit)) begin
          start       = 1'b1;
          read_start  = 1'b1;
          start_frame = {8'hF2, 16'h0000};
          start_last  = 5'd23;
          state_d     = ST_READ;
        end
      end
      ST_READ: if (xfer_done) state_d = ST_UPDATE;
      ST_UPDATE: begin
        // rx holds {DATAX0, DATAX1}; DATAX1[7:2] are sign copies and dropped.
        dig_d       = {rx_q[1:0], rx_q[15:8]};
        dig_valid_d = 1'b1;
        state_d     = ST_WAIT_TRIG;
      end
      default: state_d = ST_INIT;
    endcase

    // CS_N falls together with the first SDI bit; SCLK stays high for the lead-in.
    if (start) begin
      cs_n_d     = 1'b0;
      sclk_d     = 1'b1;
      sdi_d      = start_frame[23];
      tx_d       = {start_frame[22:0], 1'b0};
      bit_d      = 5'd0;
      last_bit_d = start_last;
      phase_d    = PH_LEAD;
      div_d      = DIV_RELOAD;
    end
  end

`ifdef GSENS_POLL_EN
  localparam int POLL_W = $clog2(POLL_CYCLES + 1);
  localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_CYCLES);

  logic [POLL_W-1:0] poll_q, poll_d;

  always_comb begin
    poll_d = (poll_q == POLL_MAX) ? poll_q : poll_q + POLL_W'(1);
    if (read_start) poll_d = '0;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) poll_q <= '0;
    else         poll_q <= poll_d;
  end

  assign poll_hit = (poll_q == POLL_MAX);
`else
  assign poll_hit = 1'b0;
`endif

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_INIT;
      phase_q     <= PH_IDLE;
      div_q       <= '0;
      bit_q       <= 5'd0;
      last_bit_q  <= 5'd0;
      tx_q        <= '0;
      rx_q        <= '0;
      sclk_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      sdi_q       <= 1'b0;
      gap_q       <= GAP_MAX;
      idx_q       <= 3'd0;
      dig_q       <= '0;
      dig_valid_q <= 1'b0;
      init_done_q <= 1'b0;
      int_meta_q  <= 1'b0;
      int_sync_q  <= 1'b0;
      sdo_meta_q  <= 1'b0;
      sdo_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      last_bit_q  <= last_bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      sdi_q       <= sdi_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      dig_q       <= dig_d;
      dig_valid_q <= dig_valid_d;
      init_done_q <= init_done_d;
      int_meta_q  <= int_meta_d;
      int_sync_q  <= int_sync_d;
      sdo_meta_q  <= sdo_meta_d;
      sdo_sync_q  <= sdo_sync_d;
    end
  end

  assign bus.oG_SCLK    = sclk_q;
  assign bus.oG_CS_N    = cs_n_q;
  assign bus.oG_SDI     = sdi_q;
  assign bus.oDIG       = dig_q;
  assign bus.oDIG_VALID = dig_valid_q;
  assign bus.oINIT_DONE = init_done_q;

endmodule

// File: tb/tb_gsens_spi_reader.sv
// Directed bench for gsens_spi_reader: SPI bus monitor plus ADXL345 response model,
// run at CLK_DIV=2, CS_GAP=4, POLL_CYCLES=1000.
module tb_gsens_spi_reader;

  localparam int CLK_DIV  = 2;
  localparam int CS_GAP   = 4;
  localparam int POLL_CYC = 1000;
  localparam int XFER_LAT = 2 * CLK_DIV * 24 + 2 * CLK_DIV + 1;

  typedef struct {
    int          fall;
    int          rise;
    int          bits;
    logic [23:0] mosi;
  } txn_t;

  logic iclk  = 1'b0;
  logic rst_n = 1'b0;
  logic int2  = 1'b0;
  logic sdo_drv = 1'b0;
  logic [23:0] rsp_word = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  gsens_spi_reader_if bus();
  assign bus.iG_SDO  = sdo_drv;
  assign bus.iG_INT2 = int2;

  gsens_spi_reader #(
    .CLK_DIV    (CLK_DIV),
    .CS_GAP     (CS_GAP),
    .POLL_CYCLES(POLL_CYC)
  ) dut (
    .iCLK  (iclk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  // Bus monitor and sensor model, sampled mid-cycle.
  txn_t        txq[$];
  int          n_falls = 0, last_fall = 0;
  int          m_fall = 0, m_bits = 0;
  logic [23:0] m_mosi = '0;
  int          hi_run = 0, lo_run = 0;
  int          err_idle = 0, err_half = 0, err_sdi = 0;
  int          vcount = 0, v_last_cyc = 0;
  logic [9:0]  v_last_dig = '0;
  int          id_rise = 0;
  logic        p_cs = 1'b1, p_sclk = 1'b1, p_sdi = 1'b0, p_id = 1'b0;

  always @(negedge iclk) begin
    logic cs, sclk, sdi;
    cs = bus.oG_CS_N; sclk = bus.oG_SCLK; sdi = bus.oG_SDI;
    if (cs && !sclk) err_idle++;
    if (p_cs && !cs) begin
      m_fall = cyc; m_bits = 0; m_mosi = '0; hi_run = 1; lo_run = 0;
      n_falls++; last_fall = cyc;
      sdo_drv = rsp_word[23];
    end else if (!cs && !p_cs) begin
      if (sclk && !p_sclk) begin
        if (lo_run != CLK_DIV) err_half++;
        if (sdi != p_sdi) err_sdi++;
        m_mosi = {m_mosi[22:0], sdi};
        m_bits++;
        hi_run = 1;
        // The model shifts out its next bit right after the master's sampling edge.
        sdo_drv = (m_bits < 24) ? rsp_word[23 - m_bits] : 1'b0;
      end else if (!sclk && p_sclk) begin
        if (hi_run != CLK_DIV) err_half++;
        lo_run = 1;
      end else begin
        if (sclk) hi_run++; else lo_run++;
        if (sdi != p_sdi) err_sdi++;
      end
    end else if (cs && !p_cs) begin
      txq.push_back('{fall: m_fall, rise: cyc, bits: m_bits, mosi: m_mosi});
    end
    if (bus.oDIG_VALID) begin
      vcount++; v_last_cyc = cyc; v_last_dig = bus.oDIG;
    end
    if (bus.oINIT_DONE && !p_id) id_rise = cyc;
    p_cs = cs; p_sclk = sclk; p_sdi = sdi; p_id = bus.oINIT_DONE;
  end

  logic [15:0] exp_w [5] = '{16'h2C0A, 16'h3100, 16'h2E80, 16'h2F80, 16'h2D08};

  task automatic tick();
    @(negedge iclk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_init(input string name);
    int budget = 3000;
    while (!bus.oINIT_DONE && budget > 0) begin tick(); budget--; end
    n_cmp++;
    if (!bus.oINIT_DONE) begin
      n_bad++; $display("FAIL %s: oINIT_DONE got 0, want 1 within 3000 cycles", name);
    end
  endtask

  task automatic wait_falls(input int target, input int budget, input string name);
    while (n_falls < target && budget > 0) begin tick(); budget--; end
    n_cmp++;
    if (n_falls < target) begin
      n_bad++; $display("FAIL %s: CS_N falls got %0d, want %0d", name, n_falls, target);
    end
  endtask

  task automatic check_writes(input string name);
    int good = 0;
    for (int i = 0; i < 5 && i < txq.size(); i++)
      if (txq[i].bits == 16 && txq[i].mosi[15:0] == exp_w[i]) good++;
    n_cmp++;
    if (good !== 5) begin
      n_bad++; $display("FAIL %s: matching config writes got %0d, want 5", name, good);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; int2 = 1'b0;
    wait_cycles(3);
    n_cmp++;
    if ({bus.oG_CS_N, bus.oG_SCLK, bus.oG_SDI, bus.oDIG_VALID, bus.oINIT_DONE} !== 5'b11000) begin
      n_bad++;
      $display("FAIL reset_pins: got %b, want 11000",
               {bus.oG_CS_N, bus.oG_SCLK, bus.oG_SDI, bus.oDIG_VALID, bus.oINIT_DONE});
    end
    n_cmp++;
    if (bus.oDIG !== 10'h000) begin
      n_bad++; $display("FAIL reset_dig: got %h, want 000", bus.oDIG);
    end
  endtask

  task automatic test_init();
    txq.delete();
    rst_n = 1'b1;
    wait_init("init_done");
    wait_cycles(2);
    n_cmp++;
    if (txq.size() !== 5) begin
      n_bad++; $display("FAIL init_count: got %0d transactions, want 5", txq.size());
    end
    for (int i = 0; i < 5 && i < txq.size(); i++) begin
      n_cmp++;
      if (txq[i].bits !== 16 || txq[i].mosi[15:0] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL init_write%0d: got %0d bits %h, want 16 bits %h",
                 i, txq[i].bits, txq[i].mosi[15:0], exp_w[i]);
      end
    end
    if (txq.size() == 5) begin
      n_cmp++;
      if (id_rise - txq[4].rise !== CS_GAP) begin
        n_bad++;
        $display("FAIL init_done_gap: got %0d, want %0d", id_rise - txq[4].rise, CS_GAP);
      end
    end
  endtask

  task automatic test_poll();
    txq.delete();
    int2 = 1'b0;
    wait_cycles(3000);
`ifdef GSENS_POLL_EN
    n_cmp++;
    if (txq.size() < 2) begin
      n_bad++; $display("FAIL poll_reads: got %0d, want >= 2", txq.size());
    end
    if (txq.size() > 0) begin
      n_cmp++;
      if (txq[0].mosi !== 24'hF20000) begin
        n_bad++; $display("FAIL poll_cmd: got %h, want F20000", txq[0].mosi);
      end
    end
`else
    n_cmp++;
    if (txq.size() !== 0) begin
      n_bad++; $display("FAIL no_poll: got %0d transactions, want 0", txq.size());
    end
`endif
  endtask

  task automatic test_read(input logic [7:0] lsb, input logic [7:0] msb,
                           input logic [9:0] exp_dig, input string name);
    int t0, v0, f0, budget;
    rsp_word = {8'h00, lsb, msb};
    txq.delete();
    v0 = vcount; f0 = n_falls;
    t0 = cyc; int2 = 1'b1;
    wait_falls(f0 + 1, 50, {name, "_start"});
    n_cmp++;
    if (last_fall - t0 > 3 + CS_GAP || last_fall - t0 < 1) begin
      n_bad++; $display("FAIL %s_latency: got %0d, want 1..%0d", name, last_fall - t0, 3 + CS_GAP);
    end
    int2 = 1'b0;
    budget = 300;
    while (vcount == v0 && budget > 0) begin tick(); budget--; end
    n_cmp++;
    if (v_last_dig !== exp_dig || vcount == v0) begin
      n_bad++; $display("FAIL %s_dig: got %h (pulses %0d), want %h", name, v_last_dig, vcount - v0, exp_dig);
    end
    n_cmp++;
    if (v_last_cyc - last_fall !== XFER_LAT) begin
      n_bad++; $display("FAIL %s_valid_lat: got %0d, want %0d", name, v_last_cyc - last_fall, XFER_LAT);
    end
    wait_cycles(300);
    n_cmp++;
    if (vcount - v0 !== 1 || bus.oDIG !== exp_dig) begin
      n_bad++;
      $display("FAIL %s_held: got %0d pulses dig %h, want 1 pulse dig %h", name, vcount - v0, bus.oDIG, exp_dig);
    end
    n_cmp++;
    if (txq.size() !== 1 || txq[0].bits !== 24 || txq[0].mosi !== 24'hF20000) begin
      n_bad++;
      $display("FAIL %s_cmd: got %0d txns first %0d bits %h, want 1 txn 24 bits F20000",
               name, txq.size(), (txq.size() > 0) ? txq[0].bits : 0,
               (txq.size() > 0) ? txq[0].mosi : 24'h0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    rsp_word = {8'h00, 8'h00, 8'h02};
    txq.delete();
    v0 = vcount; f0 = n_falls;
    int2 = 1'b1;
    wait_falls(f0 + 2, 400, "b2b_start");
    int2 = 1'b0;
    wait_cycles(300);
    n_cmp++;
    if (txq.size() !== 2 || vcount - v0 !== 2) begin
      n_bad++; $display("FAIL b2b_count: got %0d txns %0d pulses, want 2 and 2", txq.size(), vcount - v0);
    end
    if (txq.size() >= 2) begin
      n_cmp++;
      if (txq[1].fall - txq[0].rise < CS_GAP) begin
        n_bad++; $display("FAIL b2b_gap: got %0d, want >= %0d", txq[1].fall - txq[0].rise, CS_GAP);
      end
    end
    n_cmp++;
    if (bus.oDIG !== 10'h200) begin
      n_bad++; $display("FAIL b2b_dig: got %h, want 200", bus.oDIG);
    end
  endtask

  task automatic test_spi_timing();
    n_cmp++;
    if (err_idle !== 0) begin
      n_bad++; $display("FAIL sclk_idle: got %0d low-SCLK samples with CS_N high, want 0", err_idle);
    end
    n_cmp++;
    if (err_half !== 0) begin
      n_bad++; $display("FAIL half_period: got %0d bad half-periods, want 0", err_half);
    end
    n_cmp++;
    if (err_sdi !== 0) begin
      n_bad++; $display("FAIL sdi_stable: got %0d SDI changes off falling edge, want 0", err_sdi);
    end
  endtask

  task automatic test_reset_mid_read();
    int budget = 200;
    rsp_word = {8'h00, 8'h9C, 8'h03};
    int2 = 1'b1;
    while (!(bus.oG_CS_N == 1'b0 && m_bits == 10) && budget > 0) begin tick(); budget--; end
    n_cmp++;
    if (m_bits !== 10) begin
      n_bad++; $display("FAIL rst_mid_reach: got bit %0d, want 10", m_bits);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.oG_CS_N !== 1'b1 || bus.oG_SCLK !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_pins: got cs=%b sclk=%b, want 1 1", bus.oG_CS_N, bus.oG_SCLK);
    end
    n_cmp++;
    if (bus.oDIG !== 10'h000 || bus.oINIT_DONE !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_state: got dig=%h init=%b, want 000 0", bus.oDIG, bus.oINIT_DONE);
    end
    wait_cycles(3);
    txq.delete();
    rst_n = 1'b1;
    wait_init("rst_reinit");
    budget = 300;
    while (txq.size() < 6 && budget > 0) begin tick(); budget--; end
    check_writes("rst_rewrites");
    n_cmp++;
    if (txq.size() < 6 || txq[5].bits !== 24 || txq[5].fall < id_rise) begin
      n_bad++;
      $display("FAIL rst_read_after_init: got %0d txns, want a 24-bit read after oINIT_DONE", txq.size());
    end
    int2 = 1'b0;
    wait_cycles(200);
  endtask

  initial begin
    test_reset();
    test_init();
    test_poll();
    test_read(8'h9C, 8'h03, 10'h39C, "read_neg");
    test_read(8'h64, 8'h00, 10'h064, "read_pos");
    test_back_to_back();
    test_spi_timing();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
